// File: rtl/xbar_port_sched_if.sv
// Handshake bundle between NUM_M crossbar masters, one slave port and its scheduler.
// slave modport is the scheduler view; master modport is the surrounding environment.
interface xbar_port_sched_if #(
  parameter int NUM_M = 2
);
  logic [NUM_M-1:0]    req_i;
  logic [NUM_M-1:0]    cmd_i;
  logic [NUM_M*32-1:0] addr_i;
  logic [NUM_M*32-1:0] wdata_i;
  logic [NUM_M-1:0]    grant_o;
  logic [NUM_M-1:0]    ack_o;
  logic [NUM_M-1:0]    err_o;
  logic [31:0]         rdata_o;
  logic                req_o;
  logic                cmd_o;
  logic [31:0]         addr_o;
  logic [31:0]         wdata_o;
  logic                ack_i;
  logic [31:0]         rdata_i;
  logic                busy_o;

  modport slave (
    input  req_i, cmd_i, addr_i, wdata_i, ack_i, rdata_i,
    output grant_o, ack_o, err_o, rdata_o, req_o, cmd_o, addr_o, wdata_o, busy_o
  );

  modport master (
    output req_i, cmd_i, addr_i, wdata_i, ack_i, rdata_i,
    input  grant_o, ack_o, err_o, rdata_o, req_o, cmd_o, addr_o, wdata_o, busy_o
  );
endinterface

// File: rtl/xbar_port_sched.sv
// Round-robin per-slave-port scheduler: grant held IDLE->BUSY->RESP, req_o one cycle after eligibility.
// No abort: the owner waits for ack_i or the BUSY timeout; other masters wait in IDLE arbitration.
module xbar_port_sched #(
  parameter int NUM_M   = 2,
  parameter int PORT    = 0,
  parameter int SEL_BIT = 31,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  xbar_port_sched_if.slave   bus
);

  localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    sel;
  logic             sel_vld;
  logic [NUM_M-1:0] elig;
  logic [TW-1:0]    timer;
  logic             to_hit;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_M; i++) begin
      elig[i] = bus.req_i[i] & (bus.addr_i[32*i + SEL_BIT] == 1'(PORT));
    end
  end

  // Search starts at ptr and wraps, so the last owner goes to the back of the queue.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NUM_M) idx = idx - NUM_M;
      if (!sel_vld && elig[idx]) begin
        sel_vld = 1'b1;
        sel     = PW'(idx);
      end
    end
  end

  assign to_hit = (TIMEOUT != 0) && (timer == TLAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      timer       <= '0;
      bus.grant_o <= '0;
      bus.ack_o   <= '0;
      bus.err_o   <= '0;
      bus.rdata_o <= '0;
      bus.req_o   <= 1'b0;
      bus.cmd_o   <= 1'b0;
      bus.addr_o  <= '0;
      bus.wdata_o <= '0;
      bus.busy_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            owner       <= sel;
            bus.grant_o <= NUM_M'(1) << sel;
            bus.req_o   <= 1'b1;
            bus.cmd_o   <= bus.cmd_i[sel];
            bus.addr_o  <= bus.addr_i[32*int'(sel) +: 32];
            bus.wdata_o <= bus.wdata_i[32*int'(sel) +: 32];
            bus.busy_o  <= 1'b1;
            timer       <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          // ack_i takes priority over a timeout landing on the same cycle.
          if (bus.ack_i) begin
            bus.ack_o   <= NUM_M'(1) << owner;
            bus.rdata_o <= bus.rdata_i;
            bus.req_o   <= 1'b0;
            state       <= RESP;
          end else if (to_hit) begin
            bus.ack_o   <= NUM_M'(1) << owner;
            bus.err_o   <= NUM_M'(1) << owner;
            bus.rdata_o <= '0;
            bus.req_o   <= 1'b0;
            state       <= RESP;
          end else if (timer != {TW{1'b1}}) begin
            timer <= timer + TW'(1);
          end
        end
        RESP: begin
          bus.ack_o   <= '0;
          bus.err_o   <= '0;
          bus.grant_o <= '0;
          bus.cmd_o   <= 1'b0;
          bus.addr_o  <= '0;
          bus.wdata_o <= '0;
          bus.busy_o  <= 1'b0;
          ptr         <= (owner == PW'(NUM_M - 1)) ? '0 : owner + PW'(1);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_port_sched.sv
// Directed and randomized checks of xbar_port_sched: port 0 instance with a short timeout,
// port 1 instance for the address decode filter.
module tb_xbar_port_sched;

  localparam int TO = 4;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  xbar_port_sched_if #(.NUM_M(2)) a ();
  xbar_port_sched_if #(.NUM_M(2)) b ();

  xbar_port_sched #(.NUM_M(2), .PORT(0), .SEL_BIT(31), .TIMEOUT(TO)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  xbar_port_sched #(.NUM_M(2), .PORT(1), .SEL_BIT(31), .TIMEOUT(64)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int i, input logic r, input logic c,
                       input logic [31:0] ad, input logic [31:0] wd);
    a.req_i[i]          = r;
    a.cmd_i[i]          = c;
    a.addr_i[32*i +: 32]  = ad;
    a.wdata_i[32*i +: 32] = wd;
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, ".grant"}, 32'(a.grant_o), 32'h0);
    chk({tag, ".ack"},   32'(a.ack_o),   32'h0);
    chk({tag, ".err"},   32'(a.err_o),   32'h0);
    chk({tag, ".req_o"}, 32'(a.req_o),   32'h0);
    chk({tag, ".busy"},  32'(a.busy_o),  32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Round-robin reference: first requesting eligible master at or after p.
  function automatic int rr_pick(input int p, input logic [1:0] e);
    for (int k = 0; k < 2; k++) begin
      if (e[(p + k) % 2]) return (p + k) % 2;
    end
    return -1;
  endfunction

  initial begin
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic        cm [2];
    logic [1:0]  rq;
    logic [1:0]  el;
    logic [31:0] rd;
    int          ptr_m;
    int          own;
    int          d;
    int          done_at;
    bit          tmo;

    checks = 0;
    passes = 0;
    rst    = 1'b1;
    a.req_i = '0; a.cmd_i = '0; a.addr_i = '0; a.wdata_i = '0; a.ack_i = 1'b0; a.rdata_i = '0;
    b.req_i = '0; b.cmd_i = '0; b.addr_i = '0; b.wdata_i = '0; b.ack_i = 1'b0; b.rdata_i = '0;

    // Reset state
    do_reset();
    chk_a_idle("reset");
    chk("reset.rdata", a.rdata_o, 32'h0);
    chk("reset.addr",  a.addr_o,  32'h0);
    chk("reset.wdata", a.wdata_o, 32'h0);
    chk("reset.cmd",   32'(a.cmd_o), 32'h0);

    // Single master write, ack two cycles after req_o
    set_a(0, 1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5);
    tick();
    chk("single.req_o", 32'(a.req_o),   32'h1);
    chk("single.addr",  a.addr_o,       32'h0000_0010);
    chk("single.wdata", a.wdata_o,      32'hA5A5_A5A5);
    chk("single.cmd",   32'(a.cmd_o),   32'h1);
    chk("single.grant", 32'(a.grant_o), 32'h1);
    chk("single.busy",  32'(a.busy_o),  32'h1);
    tick();
    chk("single.wait_ack", 32'(a.ack_o), 32'h0);
    a.ack_i = 1'b1;
    tick();
    chk("single.ack",  32'(a.ack_o),  32'h1);
    chk("single.err",  32'(a.err_o),  32'h0);
    chk("single.drop", 32'(a.req_o),  32'h0);
    a.ack_i = 1'b0;
    a.req_i = '0;
    tick();
    chk_a_idle("single.after");

    // Decode filter on the port-1 instance
    b.req_i = 2'b11;
    b.addr_i[31:0]  = 32'h8000_0004;
    b.addr_i[63:32] = 32'h0000_0004;
    tick();
    chk("decode.grant", 32'(b.grant_o), 32'h1);
    chk("decode.addr",  b.addr_o,       32'h8000_0004);
    b.ack_i = 1'b1;
    tick();
    chk("decode.ack", 32'(b.ack_o), 32'h1);
    chk("decode.err", 32'(b.err_o), 32'h0);
    b.ack_i    = 1'b0;
    b.req_i[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("decode.m1_grant", 32'(b.grant_o[1]), 32'h0);
      chk("decode.m1_ack",   32'(b.ack_o[1] | b.err_o[1]), 32'h0);
      chk("decode.req_o",    32'(b.req_o), 32'h0);
    end
    b.req_i = '0;

    // Contention, ack_i every BUSY cycle
    do_reset();
    set_a(0, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_0000);
    set_a(1, 1'b1, 1'b1, 32'h0000_0200, 32'h2222_0000);
    a.ack_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("contend.grant", 32'(a.grant_o), (t % 2 == 0) ? 32'h1 : 32'h2);
      chk("contend.addr",  a.addr_o, (t % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      tick();
      chk("contend.ack", 32'(a.ack_o), (t % 2 == 0) ? 32'h1 : 32'h2);
      if (t == 3) begin
        a.req_i = '0;
        a.ack_i = 1'b0;
      end
      tick();
    end
    chk_a_idle("contend.after");

    // Read with address change while BUSY
    set_a(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    tick();
    chk("read.cmd",  32'(a.cmd_o), 32'h0);
    chk("read.addr", a.addr_o, 32'h0000_0100);
    set_a(0, 1'b1, 1'b1, 32'h0000_0200, 32'hFFFF_FFFF);
    tick();
    chk("read.addr_hold1", a.addr_o, 32'h0000_0100);
    chk("read.cmd_hold",   32'(a.cmd_o), 32'h0);
    tick();
    chk("read.addr_hold2", a.addr_o, 32'h0000_0100);
    a.ack_i   = 1'b1;
    a.rdata_i = 32'h1234_5678;
    tick();
    chk("read.ack",   32'(a.ack_o), 32'h1);
    chk("read.rdata", a.rdata_o,    32'h1234_5678);
    chk("read.err",   32'(a.err_o), 32'h0);
    a.ack_i   = 1'b0;
    a.rdata_i = 32'hDEAD_BEEF;
    a.req_i   = '0;
    tick();
    chk("read.ack_off",    32'(a.ack_o), 32'h0);
    chk("read.rdata_hold", a.rdata_o,    32'h1234_5678);

    // Timeout on master 1 (ptr now points at 1)
    set_a(1, 1'b1, 1'b1, 32'h0000_0040, 32'h0);
    tick();
    chk("tmo.grant", 32'(a.grant_o), 32'h2);
    for (int c = 1; c < TO; c++) begin
      tick();
      chk("tmo.pending_ack", 32'(a.ack_o), 32'h0);
      chk("tmo.pending_req", 32'(a.req_o), 32'h1);
    end
    tick();
    chk("tmo.ack",   32'(a.ack_o), 32'h2);
    chk("tmo.err",   32'(a.err_o), 32'h2);
    chk("tmo.rdata", a.rdata_o,    32'h0);
    chk("tmo.req_o", 32'(a.req_o), 32'h0);
    a.req_i = '0;
    tick();
    chk("tmo.err_off", 32'(a.err_o), 32'h0);

    // ack_i exactly on the threshold cycle
    set_a(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
    tick();
    for (int c = 1; c < TO; c++) tick();
    a.ack_i   = 1'b1;
    a.rdata_i = 32'hCAFE_F00D;
    tick();
    chk("thr.ack",   32'(a.ack_o), 32'h1);
    chk("thr.err",   32'(a.err_o), 32'h0);
    chk("thr.rdata", a.rdata_o,    32'hCAFE_F00D);
    a.ack_i = 1'b0;
    a.req_i = '0;
    tick();

    // Reset during BUSY, then arbitration restarts from master 0
    set_a(0, 1'b1, 1'b1, 32'h0000_0004, 32'h0);
    set_a(1, 1'b1, 1'b1, 32'h0000_0008, 32'h0);
    tick();
    chk("rstmid.grant_pre", 32'(a.grant_o), 32'h2);
    tick();
    rst = 1'b1;
    tick();
    chk_a_idle("rstmid");
    rst = 1'b0;
    tick();
    chk("rstmid.regrant", 32'(a.grant_o), 32'h1);
    a.ack_i = 1'b1;
    tick();
    chk("rstmid.ack", 32'(a.ack_o), 32'h1);
    a.ack_i = 1'b0;
    a.req_i = '0;
    tick();

    // Randomized transactions against the transaction-level model
    do_reset();
    ptr_m = 0;
    for (int n = 0; n < 60; n++) begin
      rq = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        ad[i] = $urandom;
        wd[i] = $urandom;
        cm[i] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0) ad[i][31] = 1'b0;
        el[i] = rq[i] && !ad[i][31];
        set_a(i, rq[i], cm[i], ad[i], wd[i]);
      end
      own = rr_pick(ptr_m, el);
      if (own < 0) begin
        tick();
        tick();
        chk("rnd.noelig_req",   32'(a.req_o),   32'h0);
        chk("rnd.noelig_grant", 32'(a.grant_o), 32'h0);
        a.req_i = '0;
        continue;
      end
      tick();
      chk("rnd.grant", 32'(a.grant_o), 32'h1 << own);
      chk("rnd.addr",  a.addr_o,       ad[own]);
      chk("rnd.wdata", a.wdata_o,      wd[own]);
      chk("rnd.cmd",   32'(a.cmd_o),   32'(cm[own]));
      for (int i = 0; i < 2; i++) set_a(i, rq[i], 1'($urandom_range(0, 1)), $urandom, $urandom);
      d       = $urandom_range(0, 5);
      tmo     = (d >= TO);
      done_at = tmo ? TO : d + 1;
      rd      = $urandom;
      for (int c = 1; c <= done_at; c++) begin
        a.ack_i   = (!tmo && c == done_at);
        a.rdata_i = rd;
        tick();
        if (c < done_at) begin
          chk("rnd.busy_ack",  32'(a.ack_o),  32'h0);
          chk("rnd.busy_addr", a.addr_o,      ad[own]);
        end
      end
      a.ack_i = 1'b0;
      chk("rnd.ack",   32'(a.ack_o), 32'h1 << own);
      chk("rnd.err",   32'(a.err_o), tmo ? (32'h1 << own) : 32'h0);
      chk("rnd.rdata", a.rdata_o,    tmo ? 32'h0 : rd);
      a.req_i = '0;
      tick();
      chk("rnd.release", 32'(a.grant_o | a.ack_o), 32'h0);
      ptr_m = (own + 1) % 2;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
